// File: rtl/reg_wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package reg_wb_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;
    localparam int NUM_REGS = 32;

    // One writeback request as seen by the register file write port.
    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus: requester-side valid/ready requests plus the register file
// write port and the in-flight write mask.
//
// Handshake: requester i transfers in a cycle where req_valid[i] and
// req_ready[i] are both high at the rising edge (and reset is low).
// req_ready is at most one-hot and depends only on req_valid and the
// arbiter's priority pointer; a requester must hold its request until it
// sees ready.
interface reg_wb_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = reg_wb_pkg::DATA_W,
    parameter int ADDR_W  = reg_wb_pkg::ADDR_W
);
    import reg_wb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_dest;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      reg_write;
    logic [ADDR_W-1:0]         reg_write_dest;
    logic [DATA_W-1:0]         reg_write_data;
    logic [NUM_REGS-1:0]       wb_pending_mask;

    // Requester / register-file side.
    modport master (
        output req_valid, req_dest, req_data,
        input  req_ready, reg_write, reg_write_dest, reg_write_data,
        input  wb_pending_mask
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_dest, req_data,
        output req_ready, reg_write, reg_write_dest, reg_write_data,
        output wb_pending_mask
    );

endinterface

// File: rtl/reg_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after the
// pointer wins; next_ptr is the slot just past the winner. The pointer
// register itself lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   next_ptr
);

    logic found;

    // Scan offsets 0..NUM_REQ-1 from ptr and grant the first valid requester.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && valid[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
                    grant[i] = 1'b1;
                    next_ptr = PTR_W'((i + 1) % NUM_REQ);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register file's single write port among NUM_REQ writeback
// requesters: round-robin grant, one registered output stage, and a one-hot
// mask of the register currently being written.
module reg_wb_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = reg_wb_pkg::DATA_W,
    parameter int ADDR_W   = reg_wb_pkg::ADDR_W,
    parameter int ZERO_REG = reg_wb_pkg::ZERO_REG
) (
    input  logic             clk,
    input  logic             reset,
    reg_wb_arbiter_if.slave  bus,
    output logic [1:0]       dbg_ptr
);
    import reg_wb_pkg::*;

    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   next_ptr;
    logic [ADDR_W-1:0]  sel_dest;
    logic [DATA_W-1:0]  sel_data;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]  dest_q, dest_d;
    logic [DATA_W-1:0]  data_q, data_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .valid    (bus.req_valid),
        .ptr      (ptr_q),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    assign bus.req_ready = grant;

    // Select the granted requester's dest/data slice.
    always_comb begin
        sel_dest = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_dest = bus.req_dest[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next pointer and output stage; writes to the zero register are
    // handshaken but never reach the register file.
    always_comb begin
        ptr_d       = ptr_q;
        reg_write_d = 1'b0;
        dest_d      = dest_q;
        data_d      = data_q;
        if (|grant) begin
            ptr_d       = next_ptr;
            dest_d      = sel_dest;
            data_d      = sel_data;
            reg_write_d = (sel_dest != ADDR_W'(ZERO_REG));
        end
    end

    // State registers; reset drops any in-flight write.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            reg_write_q <= 1'b0;
            dest_q      <= '0;
            data_q      <= '0;
        end else begin
            ptr_q       <= ptr_d;
            reg_write_q <= reg_write_d;
            dest_q      <= dest_d;
            data_q      <= data_d;
        end
    end

    // Decode the in-flight mask from registered outputs only.
    always_comb begin
        bus.wb_pending_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            bus.wb_pending_mask[r] = reg_write_q && (dest_q == ADDR_W'(r));
        end
    end

    assign bus.reg_write      = reg_write_q;
    assign bus.reg_write_dest = dest_q;
    assign bus.reg_write_data = data_q;
    assign dbg_ptr            = 2'(ptr_q);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus random
// traffic on a 2-requester and a 3-requester instance, checked against a
// cycle-level behavioural model of round-robin writeback.
module tb_reg_wb_arbiter;
    import reg_wb_pkg::*;

    logic clk;
    logic reset;
    logic [1:0] ptr2;
    logic [1:0] ptr3;

    reg_wb_arbiter_if #(.NUM_REQ(2)) bus2();
    reg_wb_arbiter_if #(.NUM_REQ(3)) bus3();

    reg_wb_arbiter #(.NUM_REQ(2)) dut2 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus2),
        .dbg_ptr (ptr2)
    );

    reg_wb_arbiter #(.NUM_REQ(3)) dut3 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus3),
        .dbg_ptr (ptr3)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int      m2_ptr = 0;
    int      m3_ptr = 0;
    wb_req_t e2, e3;
    logic    e2_wr, e3_wr;
    int      last_g2, last_g3;
    logic [2:0] last_rdy3;
    logic [63:0] dut_rf [32];
    logic [63:0] mdl_rf [32];

    // First valid requester scanning ptr, ptr+1, ... mod n; -1 if none.
    function automatic int model_grant(input logic [3:0] v, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            if (v[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    // One clock of the 2-requester DUT: apply request, check ready, advance
    // the model, then check the registered outputs after the edge.
    task automatic cycle2(input logic [1:0] v, input logic [9:0] ds,
                          input logic [127:0] xs, input string nm);
        int g;
        logic [1:0]  exp_rdy;
        logic [31:0] exp_mask;
        bus2.req_valid = v;
        bus2.req_dest  = ds;
        bus2.req_data  = xs;
        #1;
        g = model_grant({2'b00, v}, m2_ptr, 2);
        exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
        last_g2 = g;
        n_checks++;
        if (bus2.req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL %s ready2: got %b want %b", nm, bus2.req_ready, exp_rdy);
        end
        if (reset) begin
            m2_ptr = 0; e2 = '0; e2_wr = 1'b0;
        end else if (g >= 0) begin
            m2_ptr  = (g + 1) % 2;
            e2.dest = ds[g*5 +: 5];
            e2.data = xs[g*64 +: 64];
            e2_wr   = (e2.dest != 5'd31);
        end else begin
            e2_wr = 1'b0;
        end
        exp_mask = e2_wr ? (32'd1 << e2.dest) : 32'd0;
        @(posedge clk); #1;
        n_checks++;
        if (bus2.reg_write !== e2_wr) begin
            n_fail++;
            $display("FAIL %s reg_write2: got %b want %b", nm, bus2.reg_write, e2_wr);
        end
        n_checks++;
        if (bus2.reg_write_dest !== e2.dest) begin
            n_fail++;
            $display("FAIL %s dest2: got %0d want %0d", nm, bus2.reg_write_dest, e2.dest);
        end
        n_checks++;
        if (bus2.reg_write_data !== e2.data) begin
            n_fail++;
            $display("FAIL %s data2: got %h want %h", nm, bus2.reg_write_data, e2.data);
        end
        n_checks++;
        if (bus2.wb_pending_mask !== exp_mask) begin
            n_fail++;
            $display("FAIL %s mask2: got %h want %h", nm, bus2.wb_pending_mask, exp_mask);
        end
        n_checks++;
        if (ptr2 !== 2'(m2_ptr)) begin
            n_fail++;
            $display("FAIL %s ptr2: got %0d want %0d", nm, ptr2, m2_ptr);
        end
        if (bus2.reg_write === 1'b1) dut_rf[bus2.reg_write_dest] = bus2.reg_write_data;
        if (e2_wr) mdl_rf[e2.dest] = e2.data;
        @(negedge clk);
    endtask

    // One clock of the 3-requester DUT, same structure as cycle2.
    task automatic cycle3(input logic [2:0] v, input logic [14:0] ds,
                          input logic [191:0] xs, input string nm);
        int g;
        logic [2:0]  exp_rdy;
        logic [31:0] exp_mask;
        bus3.req_valid = v;
        bus3.req_dest  = ds;
        bus3.req_data  = xs;
        #1;
        g = model_grant({1'b0, v}, m3_ptr, 3);
        exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
        last_g3   = g;
        last_rdy3 = bus3.req_ready;
        n_checks++;
        if (bus3.req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL %s ready3: got %b want %b", nm, bus3.req_ready, exp_rdy);
        end
        if (reset) begin
            m3_ptr = 0; e3 = '0; e3_wr = 1'b0;
        end else if (g >= 0) begin
            m3_ptr  = (g + 1) % 3;
            e3.dest = ds[g*5 +: 5];
            e3.data = xs[g*64 +: 64];
            e3_wr   = (e3.dest != 5'd31);
        end else begin
            e3_wr = 1'b0;
        end
        exp_mask = e3_wr ? (32'd1 << e3.dest) : 32'd0;
        @(posedge clk); #1;
        n_checks++;
        if (bus3.reg_write !== e3_wr || bus3.reg_write_dest !== e3.dest ||
            bus3.reg_write_data !== e3.data) begin
            n_fail++;
            $display("FAIL %s out3: got wr=%b d=%0d x=%h want wr=%b d=%0d x=%h", nm,
                     bus3.reg_write, bus3.reg_write_dest, bus3.reg_write_data,
                     e3_wr, e3.dest, e3.data);
        end
        n_checks++;
        if (bus3.wb_pending_mask !== exp_mask) begin
            n_fail++;
            $display("FAIL %s mask3: got %h want %h", nm, bus3.wb_pending_mask, exp_mask);
        end
        n_checks++;
        if (ptr3 !== 2'(m3_ptr)) begin
            n_fail++;
            $display("FAIL %s ptr3: got %0d want %0d", nm, ptr3, m3_ptr);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus2.req_valid = '0; bus2.req_dest = '0; bus2.req_data = '0;
        bus3.req_valid = '0; bus3.req_dest = '0; bus3.req_data = '0;
        e2 = '0; e2_wr = 1'b0; e3 = '0; e3_wr = 1'b0;
        for (int r = 0; r < 32; r++) begin
            dut_rf[r] = '0; mdl_rf[r] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus2.reg_write !== 1'b0 || bus2.reg_write_dest !== 5'd0 ||
            bus2.reg_write_data !== 64'd0 || bus2.wb_pending_mask !== 32'd0 || ptr2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset2: got wr=%b d=%0d x=%h m=%h p=%0d want all zero", bus2.reg_write,
                     bus2.reg_write_dest, bus2.reg_write_data, bus2.wb_pending_mask, ptr2);
        end
        n_checks++;
        if (bus3.reg_write !== 1'b0 || bus3.reg_write_dest !== 5'd0 ||
            bus3.reg_write_data !== 64'd0 || bus3.wb_pending_mask !== 32'd0 || ptr3 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset3: got wr=%b d=%0d x=%h m=%h p=%0d want all zero", bus3.reg_write,
                     bus3.reg_write_dest, bus3.reg_write_data, bus3.wb_pending_mask, ptr3);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        cycle2(2'b01, {5'd0, 5'd5}, {64'd0, 64'hDEAD_BEEF_0000_0001}, "single");
        n_checks++;
        if (bus2.wb_pending_mask !== 32'h0000_0020 || bus2.reg_write_data !== 64'hDEAD_BEEF_0000_0001) begin
            n_fail++;
            $display("FAIL single_const: got m=%h x=%h want m=00000020 x=deadbeef00000001",
                     bus2.wb_pending_mask, bus2.reg_write_data);
        end
    endtask

    // Both requesters stream; each advances its dest only when granted.
    task automatic test_alternate();
        int c0 = 0, c1 = 0, prev = -1, alt_bad = 0;
        for (int i = 0; i < 6; i++) begin
            cycle2(2'b11, {5'(11 + c1), 5'(1 + c0)},
                   {64'(100 + c1), 64'(200 + c0)}, "alternate");
            if (last_g2 == prev) alt_bad++;
            prev = last_g2;
            if (last_g2 == 0) c0++;
            if (last_g2 == 1) c1++;
        end
        n_checks++;
        if (c0 != 3 || c1 != 3 || alt_bad != 0) begin
            n_fail++;
            $display("FAIL alternate_fair: got g0=%0d g1=%0d repeats=%0d want 3 3 0", c0, c1, alt_bad);
        end
    endtask

    task automatic test_zero_reg();
        cycle2(2'b10, {5'd31, 5'd0}, {64'h1234, 64'd0}, "zero_reg");
        n_checks++;
        if (bus2.reg_write !== 1'b0 || bus2.wb_pending_mask !== 32'd0 || last_g2 != 1) begin
            n_fail++;
            $display("FAIL zero_reg_const: got wr=%b m=%h want wr=0 m=0", bus2.reg_write,
                     bus2.wb_pending_mask);
        end
    endtask

    task automatic test_same_dest();
        cycle2(2'b01, {5'd0, 5'd3}, {64'd0, 64'h55}, "same_dest_setup");
        cycle2(2'b11, {5'd7, 5'd7}, {64'hB, 64'hA}, "same_dest_a");
        cycle2(2'b01, {5'd0, 5'd7}, {64'd0, 64'hA}, "same_dest_b");
        n_checks++;
        if (dut_rf[7] !== 64'hA || mdl_rf[7] !== 64'hA) begin
            n_fail++;
            $display("FAIL same_dest_final: got %h want a", dut_rf[7]);
        end
    endtask

    task automatic test_reset_mid();
        cycle2(2'b01, {5'd0, 5'd9}, {64'd0, 64'h99}, "reset_mid_grant");
        reset = 1'b1;
        cycle2(2'b11, {5'd12, 5'd10}, {64'h12, 64'h10}, "reset_mid_rst");
        reset = 1'b0;
        cycle2(2'b11, {5'd12, 5'd10}, {64'h12, 64'h10}, "reset_mid_after");
        n_checks++;
        if (last_g2 != 0 || bus2.reg_write_dest !== 5'd10) begin
            n_fail++;
            $display("FAIL reset_mid_first: got grant=%0d dest=%0d want 0 10", last_g2,
                     bus2.reg_write_dest);
        end
    endtask

    task automatic test_three_req();
        logic [2:0] tbl [4];
        tbl[0] = 3'b001; tbl[1] = 3'b100; tbl[2] = 3'b001; tbl[3] = 3'b100;
        for (int i = 0; i < 4; i++) begin
            cycle3(3'b101, {5'(20 + i), 5'd0, 5'(2 + i)},
                   {64'(300 + i), 64'd0, 64'(400 + i)}, "three_req");
            n_checks++;
            if (last_rdy3 !== tbl[i] || bus3.reg_write !== 1'b1) begin
                n_fail++;
                $display("FAIL three_req_seq[%0d]: got ready=%b wr=%b want %b 1", i,
                         last_rdy3, bus3.reg_write, tbl[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            cycle2(2'($urandom_range(0, 3)),
                   {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))},
                   {$urandom, $urandom, $urandom, $urandom}, "random2");
        end
        for (int i = 0; i < 150; i++) begin
            cycle3(3'($urandom_range(0, 7)),
                   {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))},
                   {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, "random3");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_zero_reg();
        test_same_dest();
        test_reset_mid();
        test_three_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
